// File: rtl/line_sched_ctrl.sv
// Output-line scheduler for a vertical scaler: paces HS/VS, the interpolation weight and FIFO read jumps.
// Optional build macro SCHED_UNDERRUN_CNT_EN adds an 8-bit saturating FIFO underrun counter output.
module line_sched_ctrl #(
  parameter int SCALE_INT_WIDTH  = 2,
  parameter int SCALE_FRAC_WIDTH = 6,
  parameter int OUTPUT_RES_WIDTH = 11
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      frameStart,
  input  logic [SCALE_INT_WIDTH+SCALE_FRAC_WIDTH-1:0] kY,
  input  logic [OUTPUT_RES_WIDTH:0]                 outYRes,
  input  logic [2:0]                                fifoNum,
  input  logic                                      lineDone,
  output logic                                      HS,
  output logic                                      VS,
  output logic [SCALE_FRAC_WIDTH-1:0]               yFrac,
  output logic                                      jmp1,
  output logic                                      jmp2,
  output logic                                      busy
`ifdef SCHED_UNDERRUN_CNT_EN
  ,
  output logic [7:0]                                underrunCnt
`endif
);

  localparam int KW = SCALE_INT_WIDTH + SCALE_FRAC_WIDTH;
  localparam int RW = OUTPUT_RES_WIDTH + 1;
  localparam int CW = SCALE_INT_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIFO,
    LINE_START,
    LINE_RUN,
    ADVANCE,
    ADVANCE2,
    FRAME_END
  } state_t;

  state_t                      state_q, state_d;
  logic [SCALE_FRAC_WIDTH-1:0] acc_q, acc_d;
  logic [RW-1:0]               line_cnt_q, line_cnt_d;
  logic [KW-1:0]               ky_q, ky_d;
  logic [RW-1:0]               res_q, res_d;
  logic                        vs_q, vs_d;

  logic [KW:0]                 step_sum;
  logic [CW-1:0]               carry;
  logic [RW-1:0]               line_cnt_inc;
  logic                        abort;

  assign abort        = frameStart && (state_q != IDLE);
  assign step_sum     = {{(SCALE_INT_WIDTH + 1){1'b0}}, acc_q} + {1'b0, ky_q};
  assign carry        = step_sum[KW:SCALE_FRAC_WIDTH];
  assign line_cnt_inc = line_cnt_q + RW'(1);

  assign HS    = (state_q == LINE_START);
  assign VS    = vs_q;
  assign yFrac = acc_q;
  assign busy  = (state_q != IDLE);

  // Carries above 3 are treated as 3: the jump pair covers at most three source lines.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    line_cnt_d = line_cnt_q;
    ky_d       = ky_q;
    res_d      = res_q;
    vs_d       = vs_q;
    jmp1       = 1'b0;
    jmp2       = 1'b0;

    if (abort) begin
      acc_d      = '0;
      line_cnt_d = '0;
      ky_d       = kY;
      res_d      = outYRes;
      vs_d       = 1'b1;
      state_d    = WAIT_FIFO;
    end else begin
      case (state_q)
        IDLE: begin
          if (frameStart && (outYRes != '0)) begin
            acc_d      = '0;
            line_cnt_d = '0;
            ky_d       = kY;
            res_d      = outYRes;
            vs_d       = 1'b1;
            state_d    = WAIT_FIFO;
          end
        end
        WAIT_FIFO: begin
          if (fifoNum >= 3'd2) state_d = LINE_START;
        end
        LINE_START: begin
          state_d = LINE_RUN;
        end
        LINE_RUN: begin
          if (lineDone) begin
            line_cnt_d = line_cnt_inc;
            if (line_cnt_inc == res_q) begin
              vs_d    = 1'b0;
              state_d = FRAME_END;
            end else begin
              state_d = ADVANCE;
            end
          end
        end
        ADVANCE: begin
          acc_d   = step_sum[SCALE_FRAC_WIDTH-1:0];
          jmp1    = (carry == CW'(1));
          jmp2    = (carry >= CW'(2));
          state_d = (carry >= CW'(3)) ? ADVANCE2 : WAIT_FIFO;
        end
        ADVANCE2: begin
          jmp1    = 1'b1;
          state_d = WAIT_FIFO;
        end
        FRAME_END: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      line_cnt_q <= '0;
      ky_q       <= '0;
      res_q      <= '0;
      vs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      line_cnt_q <= line_cnt_d;
      ky_q       <= ky_d;
      res_q      <= res_d;
      vs_q       <= vs_d;
    end
  end

`ifdef SCHED_UNDERRUN_CNT_EN
  logic       first_wait_q, first_wait_d;
  logic [7:0] underrun_q, underrun_d;

  // Only re-entries into WAIT_FIFO between lines count; the first line of a frame never does.
  always_comb begin
    first_wait_d = !abort && (state_d == WAIT_FIFO) &&
                   ((state_q == ADVANCE) || (state_q == ADVANCE2));
    underrun_d   = underrun_q;
    if ((state_q == WAIT_FIFO) && first_wait_q && (fifoNum < 3'd2) && (underrun_q != 8'hFF))
      underrun_d = underrun_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_wait_q <= 1'b0;
      underrun_q   <= '0;
    end else begin
      first_wait_q <= first_wait_d;
      underrun_q   <= underrun_d;
    end
  end

  assign underrunCnt = underrun_q;
`endif

endmodule
